vga_line_fetch: RTL and testbench
=================================

// Module: vga_line_fetch
// PURPOSE
//  Upstream pixel source for the VGA timing controller. Drives its 24-bit d_in from a
//  ping-pong line buffer, indexed by that controller's registered row_addr/col_addr.
//  While line r is displayed, fetches line (r+1) mod V_LINES from frame memory into the
//  other bank over a req/ack handshake, one pixel per beat.
//  Sits between the frame-memory port and the VGA timing controller.
// PARAMETERS
//  H_PIX      640          pixels per visible line
//  V_LINES    480          visible lines per frame
//  AW         19           frame-memory pixel-address width (640*480 < 2^19)
//  BASE_ADDR  19'h0        pixel address of frame row 0, col 0
//  ERR_COLOR  24'hFF00FF   colour driven when the displayed line is not in the buffer
// PORTS
//  vga_clk    in   1   pixel clock, 25 MHz
//  clrn       in   1   asynchronous reset, active low
//  row_addr   in   9   display row, from the VGA timing controller
//  col_addr   in   10  display column, from the VGA timing controller
//  rdn        in   1   pixel read strobe, active low, from the VGA timing controller
//  pix_data   out  24  rrrrrrrr_gggggggg_bbbbbbbb; connects to the controller's d_in
//  mem_req    out  1   fetch request, level
//  mem_addr   out  AW  pixel address of the current request
//  mem_ack    in   1   beat accepted; mem_rdata valid in the same cycle
//  mem_rdata  in   24  fetched pixel
//  underrun   out  1   sticky: displayed a line that was not fully fetched
// BEHAVIOUR
//  Reset (clrn=0, async): state=INIT, mem_req=0, mem_addr=BASE_ADDR, underrun=0,
//  both bank_valid=0, rdn_q=1.
//  pix_data is combinational, with zero latency from row_addr/col_addr/rdn:
//   - rdn=1: 24'h0.
//   - rdn=0, bank b=row_addr[0], bank_valid[b] & tag[b]==row_addr: buf[b][col_addr].
//   - otherwise: ERR_COLOR, and underrun is set on the next edge.
//  The controller registers pix_data one edge later; no extra pipeline here.
//  FSM states:
//   - INIT: unconditionally -> FETCH next cycle, with frow=0, fcol=0.
//   - IDLE: waits for trigger.
//   - FETCH: issues beats.
//  Trigger: rdn_q=1 & rdn=0 & col_addr==0 (start of a displayed line r).
//   - frow <= (r==V_LINES-1) ? 0 : r+1; fcol <= 0; -> FETCH.
//  Entering FETCH (both from INIT and from a trigger):
//   - bank_valid[frow[0]] <= 0; tag[frow[0]] <= frow.
//   - mem_addr <= BASE_ADDR + frow*640, computed as (frow<<9)+(frow<<7); no multiplier.
//  FETCH handshake:
//   - mem_req=1 with mem_addr held stable until a cycle with mem_ack=1.
//   - On ack: buf[frow[0]][fcol] <= mem_rdata; fcol++; mem_addr++. mem_req stays high
//     for back-to-back beats.
//   - Ack with fcol==H_PIX-1: bank_valid[frow[0]] <= 1; mem_req <= 0; -> IDLE.
//   - mem_ack while mem_req=0: ignored.
//  Trigger while in FETCH (previous line not done):
//   - Abort the fetch and restart at the new frow; the aborted bank stays invalid.
//   - underrun <= 1.
//   - A trigger and the final ack in the same cycle: the ack completes first, then the
//     restart is taken, without setting underrun.
//  Wrap-around: the fetch for line 0 is issued when line V_LINES-1 starts. It completes
//  during vertical blanking.
//  Writes never target the bank being displayed, because frow[0] != row_addr[0].
//  Async reset mid-fetch: mem_req drops immediately; buffer contents are don't-care;
//  valids are cleared.
//  Bandwidth: H_PIX beats must land in less than one line period (800 clocks).
//  Otherwise the result is ERR_COLOR pixels and underrun=1.
// STRUCTURE
//  Package vga_pkg: H_PIX, V_LINES, H_TOTAL=800, ERR_COLOR, typedef pixel_t [23:0],
//   fetch-state enum {INIT, IDLE, FETCH}.
//  Sub-module vga_line_ram: 2 x H_PIX x 24.
//   - Synchronous write port: bank, col, data, we.
//   - Asynchronous read port: bank, col.
//  This module holds the FSM, address generation, tags/valids and the underrun flag.
// TESTING
//  1. Reset, memory model acks every cycle. Expect:
//     - mem_addr 0..639 within 642 clocks of reset release;
//     - bank0 valid, tag 0;
//     - row 0 col 5 returns the pixel from address 5.
//  2. Displaying row 10 (trigger at col 0). Expect:
//     - first mem_addr = 11*640 = 7040;
//     - bank1 written;
//     - row 10 pixels from bank0 unaffected.
//  3. Trigger on row 479. Expect first mem_addr = 0, and row 0 of the next frame
//     displays correctly.
//  4. Memory acks every 2nd cycle (1280 clocks per line). Expect:
//     - the next trigger aborts the fetch;
//     - underrun=1;
//     - the next line shows FF00FF.
//  5. clrn pulsed low mid-FETCH at fcol=300. Expect:
//     - mem_req=0 and underrun=0 immediately;
//     - after release, the fetch restarts at address 0.
//  6. rdn=1 (blanking) with any address. Expect pix_data=0 and underrun unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, pixel type and fetch-state encoding for the VGA line fetcher.
package vga_pkg;

   localparam int H_PIX   = 640;
   localparam int V_LINES = 480;
   localparam int H_TOTAL = 800;

   localparam logic [23:0] ERR_COLOR = 24'hFF00FF;

   typedef logic [23:0] pixel_t;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      FETCH = 2'd2
   } fetch_state_t;

   // Line that has to be prefetched while line r is on screen; wraps to line 0 at frame end.
   function automatic logic [8:0] next_row(input logic [8:0] r);
      return (r == 9'(V_LINES - 1)) ? 9'd0 : r + 9'd1;
   endfunction

endpackage

// File: rtl/vga_line_fetch_if.sv
// Frame-memory fetch port: level request with a stable address, one pixel per acked beat.
interface vga_line_fetch_if #(parameter int AW = 19);
   import vga_pkg::*;

   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   pixel_t        mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/vga_line_ram.sv
// Ping-pong line buffer: two banks of one visible line each, synchronous write, asynchronous read.
module vga_line_ram
   import vga_pkg::*;
(
   input  logic       vga_clk,
   input  logic       we,
   input  logic       wr_bank,
   input  logic [9:0] wr_col,
   input  pixel_t     wr_data,
   input  logic       rd_bank,
   input  logic [9:0] rd_col,
   output pixel_t     rd_data
);

   pixel_t mem [2][H_PIX];

   always_ff @(posedge vga_clk) begin
      if (we && (wr_col < 10'(H_PIX))) begin
         mem[wr_bank][wr_col] <= wr_data;
      end
   end

   // Columns past the visible width only occur during blanking; return black rather than index out of range.
   always_comb begin
      rd_data = '0;
      if (rd_col < 10'(H_PIX)) begin
         rd_data = mem[rd_bank][rd_col];
      end
   end

endmodule

// File: rtl/vga_line_fetch.sv
// Pixel source for the VGA timing controller: serves the displayed line from one bank
// while the next line is fetched from frame memory into the other bank.
module vga_line_fetch
   import vga_pkg::*;
#(
   parameter int            AW        = 19,
   parameter logic [AW-1:0] BASE_ADDR = '0
) (
   input  logic              vga_clk,
   input  logic              clrn,
   input  logic [8:0]        row_addr,
   input  logic [9:0]        col_addr,
   input  logic              rdn,
   output pixel_t            pix_data,
   output logic              underrun,
   vga_line_fetch_if.master  mem
);

   fetch_state_t    state, state_n;
   logic [8:0]      frow, frow_n;
   logic [9:0]      fcol, fcol_n;
   logic            mem_req_q, mem_req_n;
   logic [AW-1:0]   mem_addr_q, mem_addr_n;
   logic [1:0]      bank_valid, bank_valid_n;
   logic [1:0][8:0] tag, tag_n;
   logic            underrun_q, underrun_n;
   logic            rdn_q;

   logic            trigger;
   logic            beat;
   logic            last_beat;
   logic            disp_hit;
   logic            start;
   logic [8:0]      start_row;
   pixel_t          ram_rdata;

   // Line base address as r*640 = (r<<9)+(r<<7), kept to shifts and adds.
   function automatic logic [AW-1:0] line_base(input logic [8:0] r);
      logic [AW-1:0] rw;
      rw = AW'(r);
      return BASE_ADDR + (rw << 9) + (rw << 7);
   endfunction

   assign trigger   = rdn_q & ~rdn & (col_addr == 10'd0);
   assign beat      = (state == FETCH) & mem_req_q & mem.mem_ack;
   assign last_beat = beat & (fcol == 10'(H_PIX - 1));

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;
   assign underrun     = underrun_q;

   vga_line_ram u_ram (
      .vga_clk (vga_clk),
      .we      (beat),
      .wr_bank (frow[0]),
      .wr_col  (fcol),
      .wr_data (mem.mem_rdata),
      .rd_bank (row_addr[0]),
      .rd_col  (col_addr),
      .rd_data (ram_rdata)
   );

   // Zero-latency pixel path; the controller registers it on its own edge.
   always_comb begin
      disp_hit = bank_valid[row_addr[0]] && (tag[row_addr[0]] == row_addr);
      pix_data = '0;
      if (!rdn) begin
         pix_data = disp_hit ? ram_rdata : ERR_COLOR;
      end
   end

   always_comb begin
      state_n      = state;
      frow_n       = frow;
      fcol_n       = fcol;
      mem_req_n    = mem_req_q;
      mem_addr_n   = mem_addr_q;
      bank_valid_n = bank_valid;
      tag_n        = tag;
      underrun_n   = underrun_q;
      start        = 1'b0;
      start_row    = frow;

      case (state)
         INIT: begin
            start     = 1'b1;
            start_row = 9'd0;
         end
         FETCH: begin
            if (beat) begin
               fcol_n     = fcol + 10'd1;
               mem_addr_n = mem_addr_q + AW'(1);
               if (last_beat) begin
                  bank_valid_n[frow[0]] = 1'b1;
                  mem_req_n             = 1'b0;
                  state_n               = IDLE;
               end
            end
         end
         default: ;
      endcase

      // A new line start always wins; it only counts as an underrun if the old fetch was cut short.
      if (trigger && (state != INIT)) begin
         start     = 1'b1;
         start_row = next_row(row_addr);
         if ((state == FETCH) && !last_beat) begin
            underrun_n = 1'b1;
         end
      end

      if (!rdn && !disp_hit) begin
         underrun_n = 1'b1;
      end

      // Restart overrides the completion above so the bank about to be refilled is never left valid.
      if (start) begin
         state_n                 = FETCH;
         frow_n                  = start_row;
         fcol_n                  = 10'd0;
         mem_req_n               = 1'b1;
         mem_addr_n              = line_base(start_row);
         bank_valid_n[start_row[0]] = 1'b0;
         tag_n[start_row[0]]        = start_row;
      end
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         state      <= INIT;
         frow       <= 9'd0;
         fcol       <= 10'd0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= BASE_ADDR;
         bank_valid <= 2'b00;
         tag        <= '0;
         underrun_q <= 1'b0;
         rdn_q      <= 1'b1;
      end else begin
         state      <= state_n;
         frow       <= frow_n;
         fcol       <= fcol_n;
         mem_req_q  <= mem_req_n;
         mem_addr_q <= mem_addr_n;
         bank_valid <= bank_valid_n;
         tag        <= tag_n;
         underrun_q <= underrun_n;
         rdn_q      <= rdn;
      end
   end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch: frame-memory responder, line-level reference model,
// a vector table and hand-written sequences for reset, wrap, abort and blanking.
module tb_vga_line_fetch;
   import vga_pkg::*;

   localparam int AW = 19;

   logic       vga_clk = 1'b0;
   logic       clrn;
   logic [8:0] row_addr;
   logic [9:0] col_addr;
   logic       rdn;
   pixel_t     pix_data;
   logic       underrun;

   vga_line_fetch_if #(.AW(AW)) mem ();

   vga_line_fetch #(.AW(AW), .BASE_ADDR(19'h0)) dut (
      .vga_clk  (vga_clk),
      .clrn     (clrn),
      .row_addr (row_addr),
      .col_addr (col_addr),
      .rdn      (rdn),
      .pix_data (pix_data),
      .underrun (underrun),
      .mem      (mem)
   );

   always #20 vga_clk = ~vga_clk;

   // Frame memory contents: a fixed scramble of the pixel address.
   function automatic pixel_t mem_pix(input int a);
      return pixel_t'((a * 40503) ^ 32'h00A5C3E1);
   endfunction

   assign mem.mem_rdata = mem_pix(int'(mem.mem_addr));

   int errors = 0;
   int checks = 0;

   // Reference model: which frame line each bank holds, and progress of the line in flight.
   bit m_busy, m_init_pending, m_underrun, m_rdn_prev;
   int m_line, m_idx;
   int m_line_ok [2];

   int     beat_q [$];
   pixel_t last_pix;
   logic   last_req, last_underrun;
   logic [AW-1:0] last_addr;

   typedef struct {
      int     row;
      int     col;
      bit     rd;
      pixel_t exp;
   } vec_t;
   vec_t vecs [8];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
      end
   endtask

   function automatic pixel_t model_pix(input int r, input int c, input bit rd);
      if (rd) return '0;
      if (m_line_ok[r % 2] == r) return mem_pix(r * 640 + c);
      return 24'hFF00FF;
   endfunction

   task automatic model_start(input int l);
      m_busy = 1'b1;
      m_line = l;
      m_idx  = 0;
      m_line_ok[l % 2] = -1;
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_init_pending = 1'b1;
      m_underrun = 1'b0;
      m_rdn_prev = 1'b1;
      m_line_ok[0] = -1;
      m_line_ok[1] = -1;
   endtask

   task automatic model_clock(input int r, input int c, input bit rd, input bit ak);
      if (!rd && (m_line_ok[r % 2] != r)) m_underrun = 1'b1;
      if (m_busy && ak) begin
         m_idx++;
         if (m_idx == 640) begin
            m_busy = 1'b0;
            m_line_ok[m_line % 2] = m_line;
         end
      end
      if (m_init_pending) begin
         m_init_pending = 1'b0;
         model_start(0);
      end else if (m_rdn_prev && !rd && (c == 0)) begin
         if (m_busy) m_underrun = 1'b1;
         model_start((r == 479) ? 0 : r + 1);
      end
      m_rdn_prev = rd;
   endtask

   task automatic apply_stimulus(input int r, input int c, input bit rd, input bit ak);
      @(negedge vga_clk);
      row_addr     = 9'(r);
      col_addr     = 10'(c);
      rdn          = rd;
      mem.mem_ack  = ak;
      #1;
      last_pix      = pix_data;
      last_req      = mem.mem_req;
      last_addr     = mem.mem_addr;
      last_underrun = underrun;
      check_output("pix", pix_data, model_pix(r, c, rd));
      check_output("mem_req", mem.mem_req, m_busy);
      if (m_busy) check_output("mem_addr", mem.mem_addr, m_line * 640 + m_idx);
      check_output("underrun", underrun, m_underrun);
      if (mem.mem_req && ak) beat_q.push_back(int'(mem.mem_addr));
      @(posedge vga_clk);
      model_clock(r, c, rd, ak);
   endtask

   task automatic show_line(input int r, input int active, input int blank, input int mode);
      bit ak;
      for (int c = 0; c < active + blank; c++) begin
         case (mode)
            0:       ak = 1'b1;
            1:       ak = (c % 2) == 1;
            default: ak = $urandom_range(0, 9) != 0;
         endcase
         apply_stimulus(r, c, c >= active, ak);
      end
   endtask

   task automatic pulse_reset();
      @(negedge vga_clk);
      #2;
      clrn = 1'b0;
      rdn = 1'b1;
      mem.mem_ack = 1'b0;
      #1;
      check_output("reset_req", mem.mem_req, 1'b0);
      check_output("reset_underrun", underrun, 1'b0);
      row_addr = 9'd0;
      col_addr = 10'd0;
      rdn = 1'b0;
      #1;
      check_output("reset_pix", pix_data, 24'hFF00FF);
      rdn = 1'b1;
      repeat (2) @(posedge vga_clk);
      #5;
      clrn = 1'b1;
      model_reset();
   endtask

   function automatic int first_beat();
      return (beat_q.size() > 0) ? beat_q[0] : -1;
   endfunction

   initial begin
      bit reached;
      clrn = 1'b1;
      rdn = 1'b1;
      row_addr = '0;
      col_addr = '0;
      mem.mem_ack = 1'b0;

      vecs[0] = '{11,    5, 1'b0, mem_pix(11 * 640 + 5)};
      vecs[1] = '{12,  639, 1'b0, mem_pix(12 * 640 + 639)};
      vecs[2] = '{11,  639, 1'b0, mem_pix(11 * 640 + 639)};
      vecs[3] = '{3,    17, 1'b1, 24'h0};
      vecs[4] = '{479, 1023, 1'b1, 24'h0};
      vecs[5] = '{12,    0, 1'b1, 24'h0};
      vecs[6] = '{11,    0, 1'b1, 24'h0};
      vecs[7] = '{12,    1, 1'b0, mem_pix(12 * 640 + 1)};

      // Line 0 is fetched straight out of reset.
      pulse_reset();
      beat_q.delete();
      for (int i = 0; i < 642; i++) apply_stimulus(0, 0, 1'b1, 1'b1);
      check_output("init_beats", beat_q.size(), 640);
      if (beat_q.size() == 640) begin
         check_output("init_first_addr", beat_q[0], 0);
         check_output("init_last_addr", beat_q[639], 639);
      end
      apply_stimulus(0, 5, 1'b0, 1'b1);
      check_output("row0_col5", last_pix, mem_pix(5));
      apply_stimulus(0, 5, 1'b1, 1'b1);

      for (int r = 0; r < 12; r++) begin
         if (r == 10) beat_q.delete();
         show_line(r, 640, 60, 0);
         if (r == 10) begin
            check_output("row10_first_addr", first_beat(), 7040);
            check_output("row10_beats", beat_q.size(), 640);
            apply_stimulus(10, 100, 1'b0, 1'b1);
            check_output("row10_after_fetch", last_pix, mem_pix(10 * 640 + 100));
            apply_stimulus(10, 100, 1'b1, 1'b1);
         end
      end

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].row, vecs[i].col, vecs[i].rd, 1'b1);
         check_output($sformatf("vec%0d", i), last_pix, vecs[i].exp);
      end

      // Blanking with arbitrary addresses never flags an underrun.
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)), 1'b1, $urandom_range(0, 1) == 1);
         check_output("blank_pix", last_pix, 24'h0);
      end
      check_output("blank_underrun", last_underrun, 1'b0);

      // Half-rate memory: the fetch of line 13 cannot finish before row 13 starts.
      show_line(12, 640, 60, 1);
      apply_stimulus(13, 0, 1'b0, 1'b0);
      apply_stimulus(13, 1, 1'b0, 1'b1);
      check_output("abort_underrun", last_underrun, 1'b1);
      check_output("abort_err_pix", last_pix, 24'hFF00FF);
      reached = 1'b0;
      for (int c = 2; c < 1000 && !reached; c++) begin
         if (m_busy && (m_idx == 300)) reached = 1'b1;
         else apply_stimulus(13, c, c >= 640, (c % 2) == 1);
      end
      check_output("fcol300_reached", reached, 1'b1);

      // Reset in the middle of a fetch, then the fetch restarts at line 0.
      pulse_reset();
      apply_stimulus(0, 0, 1'b1, 1'b1);
      apply_stimulus(0, 0, 1'b1, 1'b1);
      check_output("restart_req", last_req, 1'b1);
      check_output("restart_addr", last_addr, 0);
      for (int i = 0; i < 640; i++) apply_stimulus(0, 0, 1'b1, 1'b1);

      // Last line of the frame prefetches line 0.
      beat_q.delete();
      show_line(479, 640, 60, 0);
      check_output("wrap_first_addr", first_beat(), 0);
      show_line(0, 640, 60, 0);
      apply_stimulus(0, 5, 1'b0, 1'b1);
      check_output("wrap_row0_col5", last_pix, mem_pix(5));
      apply_stimulus(0, 5, 1'b1, 1'b1);

      // Randomly stalling memory with randomly sized horizontal blanking.
      for (int r = 1; r <= 6; r++) begin
         show_line(r, 640, int'($urandom_range(40, 140)), 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
